// File: rtl/switch_pkg.sv
// Shared constants for the CPU-to-switch ingress path: bus widths, port count,
// Avalon register map and status/control bit positions.
package switch_pkg;

    localparam int DW     = 8;
    localparam int NPORTS = 3;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_PUSH0  = 3'd1;
    localparam logic [2:0] ADDR_PUSH1  = 3'd2;
    localparam logic [2:0] ADDR_PUSH2  = 3'd3;
    localparam logic [2:0] ADDR_STAT0  = 3'd4;
    localparam logic [2:0] ADDR_STAT1  = 3'd5;
    localparam logic [2:0] ADDR_STAT2  = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    localparam int STATUS_EMPTY_LSB = 0;
    localparam int STATUS_FULL_LSB  = 3;
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_OVF_LSB     = 1;

endpackage

// File: rtl/ingress_fifo.sv
// Show-ahead FIFO feeding one switch input: push/pop/flush, head byte, fill count,
// full and empty flags. Flush takes priority over push and pop in the same cycle.
module ingress_fifo #(
    parameter int  DEPTH = 64,
    parameter int  DW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    // Full is judged on the pre-cycle count, so a same-cycle pop never makes room.
    assign push_ok_s = push & ~full_s & ~flush;
    assign pop_ok_s  = pop & ~empty_s & ~flush;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

    // Head byte, forced to zero while empty.
    always_comb begin
        head = {DW{1'b0}};
        if (empty_s) begin
            head = {DW{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/ingress_loader.sv
// Avalon-MM slave loading CPU bytes into per-port FIFOs that stream into the switch inputs.
// Optional per-port issued-byte counters are built when INGRESS_STATS_EN is defined.
module ingress_loader
    import switch_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [2:0]           address,
    input  logic [DW-1:0]        writedata,
    output logic [DW-1:0]        readdata,
    output logic [NPORTS*DW-1:0] tx_data,
    output logic [NPORTS-1:0]    tx_valid,
    input  logic [NPORTS-1:0]    tx_ready
);

    localparam int AW = $clog2(DEPTH);

    logic              wr_s;
    logic              rd_s;
    logic [NPORTS-1:0] push_s;
    logic [NPORTS-1:0] flush_s;
    logic [NPORTS-1:0] pop_s;
    logic [NPORTS-1:0] full_s;
    logic [NPORTS-1:0] empty_s;
    logic [NPORTS-1:0] ovf_set_s;
    logic [NPORTS-1:0] ovf_clr_s;
    logic [AW:0]       count_s [NPORTS];
    logic [DW-1:0]     head_s [NPORTS];
    logic [DW-1:0]     stat_view_s [NPORTS];
    logic [DW-1:0]     rd_mux_s;
    logic              enable_r;
    logic [NPORTS-1:0] ovf_r;
    logic [DW-1:0]     readdata_r;

    assign wr_s      = chipselect & write;
    assign rd_s      = chipselect & read;
    assign tx_valid  = {NPORTS{enable_r}} & ~empty_s;
    assign pop_s     = tx_valid & tx_ready;
    // A push dropped by a same-cycle flush is not an overflow.
    assign ovf_set_s = push_s & full_s & ~flush_s;

    // Write decode: pushes, flush mask and overflow clear.
    always_comb begin
        push_s    = {NPORTS{1'b0}};
        flush_s   = {NPORTS{1'b0}};
        ovf_clr_s = {NPORTS{1'b0}};
        if (wr_s) begin
            case (address)
                ADDR_STATUS: flush_s   = writedata[STATUS_EMPTY_LSB +: NPORTS];
                ADDR_PUSH0:  push_s    = 3'b001;
                ADDR_PUSH1:  push_s    = 3'b010;
                ADDR_PUSH2:  push_s    = 3'b100;
                ADDR_CTRL:   ovf_clr_s = writedata[CTRL_OVF_LSB +: NPORTS];
                default:     push_s    = {NPORTS{1'b0}};
            endcase
        end else begin
            push_s = {NPORTS{1'b0}};
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        ingress_fifo #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push_s[p]),
            .pop     (pop_s[p]),
            .flush   (flush_s[p]),
            .wdata   (writedata),
            .head    (head_s[p]),
            .count   (count_s[p]),
            .full    (full_s[p]),
            .empty   (empty_s[p])
        );
        assign tx_data[p*DW +: DW] = head_s[p];
    end

    // Enable bit and sticky overflow flags; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_r <= 1'b0;
            ovf_r    <= {NPORTS{1'b0}};
        end else begin
            if (wr_s && (address == ADDR_CTRL)) enable_r <= writedata[CTRL_EN_BIT];
            ovf_r <= (ovf_r & ~ovf_clr_s) | ovf_set_s;
        end
    end

`ifdef INGRESS_STATS_EN
    logic [7:0] stat_r [NPORTS];

    // Issued-byte counters: wrap at 255, cleared together with their FIFO.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (!reset_n || flush_s[p]) begin
                stat_r[p] <= 8'd0;
            end else if (pop_s[p]) begin
                stat_r[p] <= stat_r[p] + 8'd1;
            end
        end
    end

    // Counter view for the register read mux.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) stat_view_s[p] = DW'(stat_r[p]);
    end
`else
    // Counters are not built; their addresses read as zero.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) stat_view_s[p] = {DW{1'b0}};
    end
`endif

    // Register read mux.
    always_comb begin
        rd_mux_s = {DW{1'b0}};
        case (address)
            ADDR_STATUS: rd_mux_s = DW'({full_s, empty_s});
            ADDR_PUSH0:  rd_mux_s = DW'(count_s[0]);
            ADDR_PUSH1:  rd_mux_s = DW'(count_s[1]);
            ADDR_PUSH2:  rd_mux_s = DW'(count_s[2]);
            ADDR_STAT0:  rd_mux_s = stat_view_s[0];
            ADDR_STAT1:  rd_mux_s = stat_view_s[1];
            ADDR_STAT2:  rd_mux_s = stat_view_s[2];
            ADDR_CTRL:   rd_mux_s = DW'({ovf_r, enable_r});
            default:     rd_mux_s = {DW{1'b0}};
        endcase
    end

    // Registered read data, zero on cycles without a read strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_r <= {DW{1'b0}};
        end else if (rd_s) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= {DW{1'b0}};
        end
    end

    assign readdata = readdata_r;

endmodule

// File: tb/tb_ingress_loader.sv
// Self-checking bench for ingress_loader: register reads checked directly, streamed
// bytes checked against per-port expected queues filled as writes are issued.
module tb_ingress_loader;

    localparam int DEPTH = 64;
`ifdef INGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [23:0] tx_data;
    logic [2:0]  tx_valid;
    logic [2:0]  tx_ready;

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q [3][$];
    logic [2:0] ovf_m;
    logic       en_m;
    logic [7:0] rdv;

    ingress_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) exp_q[p].delete();
        ovf_m = 3'b000;
        en_m  = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        int p;
        case (a)
            3'd0: for (int k = 0; k < 3; k++) if (d[k]) exp_q[k].delete();
            3'd1, 3'd2, 3'd3: begin
                p = int'(a) - 1;
                if (exp_q[p].size() < DEPTH) exp_q[p].push_back(d);
                else ovf_m[p] = 1'b1;
            end
            3'd7: begin
                en_m  = d[0];
                ovf_m = ovf_m & ~d[3:1];
            end
            default: ;
        endcase
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        model_write(a, d);
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic check_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        chk(tag, {24'd0, v}, {24'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int p, input int budget);
        int n = 0;
        while (exp_q[p].size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", {31'd0, exp_q[p].size() != 0}, 32'd0);
        idle(1);
    endtask

    // Scoreboard: every handshake seen mid-cycle must carry the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int p = 0; p < 3; p++) begin
                if (tx_valid[p] && tx_ready[p] &&
                    !(chipselect && write && address == 3'd0 && writedata[p])) begin
                    if (exp_q[p].size() == 0) begin
                        chk($sformatf("sb_extra_p%0d", p), {24'd0, tx_data[p*8 +: 8]}, 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("sb_data_p%0d", p), {24'd0, tx_data[p*8 +: 8]},
                            {24'd0, exp_q[p].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 8'd0; tx_ready = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        chk("rst_tx_valid", {29'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {8'd0, tx_data}, 32'd0);
        check_rd("rst_status", 3'd0, 8'h07);
        check_rd("rst_ctrl", 3'd7, 8'h00);
        idle(1);
        chk("rd_idle_zero", {24'd0, readdata}, 32'd0);

        // Port 0 stream of three bytes
        wr(3'd1, 8'h11); wr(3'd1, 8'h22); wr(3'd1, 8'h33);
        check_rd("p0_count3", 3'd1, 8'd3);
        chk("p0_hold_disabled", {29'd0, tx_valid}, 32'd0);
        tx_ready = 3'b001;
        wr(3'd7, 8'h01);
        idle(3);
        chk("p0_drained_valid", {29'd0, tx_valid}, 32'd0);
        chk("p0_drained_q", exp_q[0].size(), 32'd0);
        tx_ready = 3'b000;
        check_rd("p0_stats", 3'd4, STATS ? 8'd3 : 8'd0);

        // Port 1 overflow
        for (int i = 0; i < DEPTH; i++) wr(3'd2, 8'(i + 1));
        wr(3'd2, 8'hAA);
        check_rd("p1_full_status", 3'd0, 8'h15);
        check_rd("p1_ovf_ctrl", 3'd7, {4'd0, ovf_m, en_m});
        check_rd("p1_count_full", 3'd2, 8'd64);
        wr(3'd7, 8'h05);
        check_rd("p1_ovf_cleared", 3'd7, {4'd0, ovf_m, en_m});
        tx_ready = 3'b010;
        drain(1, DEPTH + 10);
        tx_ready = 3'b000;
        check_rd("p1_count_empty", 3'd2, 8'd0);
        check_rd("p1_stats", 3'd5, STATS ? 8'd64 : 8'd0);

        // Port 2 concurrent push and pop around half full
        for (int i = 0; i < 32; i++) wr(3'd3, 8'h40 + 8'(i));
        check_rd("p2_half", 3'd3, 8'd32);
        for (int i = 0; i < 8; i++) begin
            tx_ready = (i % 2 == 0) ? 3'b100 : 3'b000;
            wr(3'd3, 8'h80 + 8'(i));
        end
        tx_ready = 3'b000;
        check_rd("p2_after_toggle", 3'd3, 8'd36);
        tx_ready = 3'b100;
        wr(3'd3, 8'hC0);
        tx_ready = 3'b000;
        check_rd("p2_pushpop_same", 3'd3, 8'd36);
        tx_ready = 3'b100;
        drain(2, 100);
        tx_ready = 3'b000;
        check_rd("p2_stats", 3'd6, STATS ? 8'd41 : 8'd0);

        // Flush beats a concurrent pop
        for (int i = 0; i < 5; i++) wr(3'd1, 8'hD0 + 8'(i));
        tx_ready = 3'b001;
        wr(3'd0, 8'h01);
        tx_ready = 3'b000;
        check_rd("flush_count", 3'd1, 8'd0);
        check_rd("flush_status", 3'd0, 8'h07);
        check_rd("flush_stats", 3'd4, 8'd0);

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            wr(3'd1, 8'h60 + 8'(i));
            wr(3'd3, 8'h70 + 8'(i));
        end
        chk("pre_reset_valid", {29'd0, tx_valid}, 32'h5);
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("mid_reset_valid", {29'd0, tx_valid}, 32'd0);
        chk("mid_reset_data", {8'd0, tx_data}, 32'd0);
        reset_n = 1'b1;
        check_rd("post_reset_count0", 3'd1, 8'd0);
        check_rd("post_reset_count2", 3'd3, 8'd0);
        check_rd("post_reset_ctrl", 3'd7, 8'h00);
        check_rd("post_reset_status", 3'd0, 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
